// File: rtl/wb_dp_ram_pipe.sv
// wb_dp_ram_pipe: true dual-port pipelined Wishbone RAM, read-first, port A wins byte collisions
module wb_dp_ram_pipe #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 16,
  parameter int    SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int    MEM_WORDS    = 2 ** (ADDR_WIDTH - $clog2(SELECT_WIDTH)),
  parameter int    OUT_REG      = 0,
  parameter string INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   a_adr_i,
  input  logic [DATA_WIDTH-1:0]   a_dat_i,
  output logic [DATA_WIDTH-1:0]   a_dat_o,
  input  logic                    a_we_i,
  input  logic [SELECT_WIDTH-1:0] a_sel_i,
  input  logic                    a_stb_i,
  input  logic                    a_cyc_i,
  output logic                    a_ack_o,
  output logic                    a_err_o,
  output logic                    a_stall_o,
  input  logic [ADDR_WIDTH-1:0]   b_adr_i,
  input  logic [DATA_WIDTH-1:0]   b_dat_i,
  output logic [DATA_WIDTH-1:0]   b_dat_o,
  input  logic                    b_we_i,
  input  logic [SELECT_WIDTH-1:0] b_sel_i,
  input  logic                    b_stb_i,
  input  logic                    b_cyc_i,
  output logic                    b_ack_o,
  output logic                    b_err_o,
  output logic                    b_stall_o
);
  localparam int LW  = $clog2(SELECT_WIDTH);
  localparam int VAW = ADDR_WIDTH - LW;
  localparam int MW  = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [1:0] cyc, stb, we, acc, rng, ack, err;
  logic [1:0][VAW-1:0] idx;
  logic [1:0][SELECT_WIDTH-1:0] sel, wl;
  logic [1:0][DATA_WIDTH-1:0] wd, dat;

  assign cyc = {b_cyc_i, a_cyc_i};
  assign stb = {b_stb_i, a_stb_i};
  assign we  = {b_we_i, a_we_i};
  assign sel = {b_sel_i, a_sel_i};
  assign wd  = {b_dat_i, a_dat_i};
  assign idx = {b_adr_i[ADDR_WIDTH-1:LW], a_adr_i[ADDR_WIDTH-1:LW]};

  if (LW > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^{a_adr_i[LW-1:0], b_adr_i[LW-1:0]};
  end

  // B lanes are written first so that A overrides them on a same-word, same-lane collision
  always_ff @(posedge clk)
    for (int i = 0; i < SELECT_WIDTH; i++) begin
      if (wl[1][i]) mem[idx[1][MW-1:0]][i*8 +: 8] <= wd[1][i*8 +: 8];
      if (wl[0][i]) mem[idx[0][MW-1:0]][i*8 +: 8] <= wd[0][i*8 +: 8];
    end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic v1, e1, v2, e2;
    logic [DATA_WIDTH-1:0] q, d2;
    assign acc[p] = cyc[p] & stb[p] & ~rst;
    assign rng[p] = 32'(idx[p]) < MEM_WORDS;
    assign wl[p]  = sel[p] & {SELECT_WIDTH{acc[p] & we[p] & rng[p]}};
    always_ff @(posedge clk)
      if (rst) begin
        v1 <= 1'b0;
        e1 <= 1'b0;
        v2 <= 1'b0;
        e2 <= 1'b0;
        q  <= '0;
        d2 <= '0;
      end else begin
        v1 <= acc[p];
        e1 <= ~rng[p];
        v2 <= v1 & cyc[p];
        e2 <= e1;
        if (acc[p]) q <= rng[p] ? mem[idx[p][MW-1:0]] : '0;
        if (v1 & cyc[p]) d2 <= q;
      end
    assign ack[p] = OUT_REG != 0 ? v2 & ~e2 : v1 & ~e1;
    assign err[p] = OUT_REG != 0 ? v2 & e2 : v1 & e1;
    assign dat[p] = OUT_REG != 0 ? d2 : q;
  end

  assign a_ack_o   = ack[0];
  assign b_ack_o   = ack[1];
  assign a_err_o   = err[0];
  assign b_err_o   = err[1];
  assign a_dat_o   = dat[0];
  assign b_dat_o   = dat[1];
  assign a_stall_o = 1'b0;
  assign b_stall_o = 1'b0;
endmodule
